// File: rtl/multi_edge_detector_pkg.sv
// Shared constants for the multi-channel debounced edge detector.
// Mode encodings select which level transitions raise a pulse.
package multi_edge_detector_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 32;
    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 4;
    localparam int DEB_W_MIN    = 1;
    localparam int DEB_W_MAX    = 16;

endpackage

// File: rtl/multi_edge_detector_edge_channel.sv
// One detector channel: synchronizer, debounce counter,
// edge detect with mode select and sticky event flag.
module edge_channel
    import multi_edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic [DEB_W-1:0] deb_len,
    input  logic             clr,
    output logic             level,
    output logic             pulse,
    output logic             flag
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   flag_q, flag_d;
    logic                   sync;
    logic                   toggle;
    logic                   rise_en;
    logic                   fall_en;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        sync    = sync_q[SYNC_STAGES-1];
        rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
        fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);
        toggle  = 1'b0;
        level_d = level_q;
        cnt_d   = '0;
        // cnt only climbs while below deb_len, so it cannot wrap
        if (sync != level_q) begin
            if (cnt_q >= deb_len) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
        pulse_d = toggle & (level_q ? fall_en : rise_en);
        flag_d  = pulse_d | (flag_q & ~clr);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;
    assign flag  = flag_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with sticky flags
// and a combined interrupt line.
module multi_edge_detector
    import multi_edge_detector_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [DEB_W-1:0]      deb_len,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   flag,
    output logic                  irq
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_W      (DEB_W)
        ) u_ch (
            .clk    (clk),
            .n_rst  (n_rst),
            .din    (in[i]),
            .mode   (mode[2*i+1:2*i]),
            .deb_len(deb_len),
            .clr    (clr[i]),
            .level  (level[i]),
            .pulse  (pulse[i]),
            .flag   (flag[i])
        );
    end

    assign irq = |flag;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (defaults: 4 ch,
// 2 sync stages, 4-bit debounce counter).
module tb_multi_edge_detector;

    logic       clk;
    logic       n_rst;
    logic [3:0] in;
    logic [7:0] mode;
    logic [3:0] deb_len;
    logic [3:0] clr;
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] flag;
    logic       irq;

    int tests;
    int fails;

    multi_edge_detector dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .in     (in),
        .mode   (mode),
        .deb_len(deb_len),
        .clr    (clr),
        .level  (level),
        .pulse  (pulse),
        .flag   (flag),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        n_rst   = 1'b0;
        in      = '0;
        mode    = '0;
        deb_len = '0;
        clr     = '0;
        #1;
        tests++;
        if ({level, pulse, flag, irq} !== 13'd0) begin
            fails++;
            $display("FAIL reset_state got=%h exp=0",
                     {level, pulse, flag, irq});
        end
        steps(2);
        n_rst = 1'b1;
        steps(2);
        tests++;
        if ({level, pulse, flag, irq} !== 13'd0) begin
            fails++;
            $display("FAIL post_reset got=%h exp=0",
                     {level, pulse, flag, irq});
        end
    endtask

    task automatic test_basic();
        logic [3:0] p1, p2;
        int seen;
        mode    = 8'b0000_0001;
        deb_len = 4'd0;
        in[0]   = 1'b1;
        step();
        p1 = pulse;
        step();
        p2 = pulse;
        tests++;
        if ({p1[0], p2[0]} !== 2'b00) begin
            fails++;
            $display("FAIL basic_early got=%b exp=00",
                     {p1[0], p2[0]});
        end
        step();
        tests++;
        if ({pulse[0], level[0], flag[0], irq} !== 4'b1111) begin
            fails++;
            $display("FAIL basic_edge3 got=%b exp=1111",
                     {pulse[0], level[0], flag[0], irq});
        end
        step();
        tests++;
        if ({pulse[0], flag[0]} !== 2'b01) begin
            fails++;
            $display("FAIL basic_width got=%b exp=01",
                     {pulse[0], flag[0]});
        end
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        in[0]  = 1'b0;
        seen   = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (pulse[0]) seen++;
        end
        tests++;
        if ({level[0], flag[0]} !== 2'b00 || seen != 0) begin
            fails++;
            $display("FAIL basic_fall lvl/flg=%b pulses=%0d exp=00/0",
                     {level[0], flag[0]}, seen);
        end
    endtask

    task automatic test_glitch();
        int seen;
        int lat;
        mode    = 8'b0000_0100;
        deb_len = 4'd3;
        in[1]   = 1'b1;
        steps(2);
        in[1]   = 1'b0;
        seen    = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (pulse[1] || level[1]) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL glitch_reject got=%0d exp=0", seen);
        end
        in[1] = 1'b1;
        lat   = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            if (pulse[1]) lat = k;
        end
        tests++;
        if (lat != 6) begin
            fails++;
            $display("FAIL glitch_latency got=%0d exp=6", lat);
        end
        in[1] = 1'b0;
        steps(10);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        tests++;
        if ({level[1], flag[1]} !== 2'b00) begin
            fails++;
            $display("FAIL glitch_settle got=%b exp=00",
                     {level[1], flag[1]});
        end
    endtask

    task automatic test_both();
        int cnt;
        mode    = 8'b0011_0000;
        deb_len = 4'd0;
        cnt     = 0;
        in[2]   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (pulse[2]) cnt++;
        end
        in[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (pulse[2]) cnt++;
        end
        tests++;
        if (cnt != 2 || flag[2] !== 1'b1) begin
            fails++;
            $display("FAIL both_edges pulses=%0d flag=%b exp=2/1",
                     cnt, flag[2]);
        end
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        tests++;
        if (flag[2] !== 1'b0) begin
            fails++;
            $display("FAIL both_clr got=%b exp=0", flag[2]);
        end
    endtask

    task automatic test_mode_off();
        int seen;
        mode    = 8'b0000_0000;
        deb_len = 4'd0;
        in[3]   = 1'b1;
        seen    = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (pulse[3] || flag[3]) seen++;
        end
        tests++;
        if (level[3] !== 1'b1 || seen != 0) begin
            fails++;
            $display("FAIL mode_off lvl=%b hits=%0d exp=1/0",
                     level[3], seen);
        end
        in[3] = 1'b0;
        steps(6);
    endtask

    task automatic test_clr_collision();
        mode    = 8'b0100_0000;
        deb_len = 4'd0;
        in[3]   = 1'b1;
        steps(2);
        clr[3]  = 1'b1;
        step();
        tests++;
        if ({pulse[3], flag[3]} !== 2'b11) begin
            fails++;
            $display("FAIL clr_set_wins got=%b exp=11",
                     {pulse[3], flag[3]});
        end
        step();
        clr[3] = 1'b0;
        tests++;
        if ({flag[3], irq} !== 2'b00) begin
            fails++;
            $display("FAIL clr_next got=%b exp=00",
                     {flag[3], irq});
        end
        in[3] = 1'b0;
        steps(6);
    endtask

    task automatic test_deb_lower();
        logic early;
        mode    = 8'b0000_0001;
        deb_len = 4'd10;
        in[0]   = 1'b1;
        early   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (pulse[0] || level[0]) early = 1'b1;
        end
        deb_len = 4'd2;
        step();
        tests++;
        if (early !== 1'b0 || {pulse[0], level[0]} !== 2'b11) begin
            fails++;
            $display("FAIL deb_lower early=%b got=%b exp=0/11",
                     early, {pulse[0], level[0]});
        end
        deb_len = 4'd0;
        in[0]   = 1'b0;
        steps(5);
        clr = 4'hF;
        step();
        clr = 4'h0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] early;
        mode    = 8'b0101_0101;
        deb_len = 4'd0;
        in      = 4'hF;
        steps(3);
        tests++;
        if ({pulse, level, flag} !== 12'hFFF) begin
            fails++;
            $display("FAIL all_ch got=%h exp=fff",
                     {pulse, level, flag});
        end
        deb_len = 4'd5;
        in      = 4'h0;
        steps(4);
        in      = 4'hF;
        #2;
        n_rst   = 1'b0;
        #1;
        tests++;
        if ({level, pulse, flag, irq} !== 13'd0) begin
            fails++;
            $display("FAIL async_reset got=%h exp=0",
                     {level, pulse, flag, irq});
        end
        steps(2);
        n_rst = 1'b1;
        early = '0;
        for (int k = 1; k <= 7; k++) begin
            step();
            early = early | pulse | level;
        end
        step();
        tests++;
        if (early !== 4'h0 || pulse !== 4'hF) begin
            fails++;
            $display("FAIL reset_release early=%h pulse=%h exp=0/f",
                     early, pulse);
        end
        step();
        tests++;
        if (pulse !== 4'h0 || flag !== 4'hF || irq !== 1'b1) begin
            fails++;
            $display("FAIL release_after p=%h f=%h irq=%b exp=0/f/1",
                     pulse, flag, irq);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_glitch();
        test_both();
        test_mode_off();
        test_clr_collision();
        test_deb_lower();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
